pixel_event_encoder: RTL and testbench

Latency-coding event source for the L1 spiking layer. Accepts one p_s-pixel digit frame over a valid/ready stream. Re-emits it as single-synapse events on a one-hot vector that drives the L1 event input. Brighter pixels fire earlier; events are serialized one per emission with a programmable inter-event gap, so synapse traces decay between events.

---
 rtl/pixel_event_encoder_pkg.sv | 25 ++
 rtl/pixel_event_encoder_lsb_onehot.sv | 17 +
 rtl/pixel_event_encoder.sv | 173 +++++++++++++++++
 tb/tb_pixel_event_encoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_event_encoder_pkg.sv
// pixel_event_encoder_pkg
// Shared definitions for the pixel latency encoder: FSM state encoding and
// helpers that derive the latency-slot width and the last slot index from
// the pixel width and the latency shift.
package pixel_event_encoder_pkg;

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_SCAN = 3'd1,
    ST_EMIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Number of bits left in the inverted intensity after the latency shift.
  function automatic int calc_slot_width(input int width, input int shift);
    return width - shift;
  endfunction

  // Index of the last latency slot for a given slot width.
  function automatic int calc_smax(input int sw);
    return (1 << sw) - 1;
  endfunction

endpackage

// File: rtl/pixel_event_encoder_lsb_onehot.sv
// lsb_onehot
// Combinational lowest-set-bit isolator.
// Ports:
//   vec_i     input vector
//   onehot_o  vec_i with every bit cleared except its lowest set bit
//             (all zero when vec_i is zero)
module lsb_onehot #(
  parameter int p_w = 25
) (
  input  logic [p_w-1:0] vec_i,
  output logic [p_w-1:0] onehot_o
);

  // Two's complement trick: x & -x keeps only the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + p_w'(1));

endmodule

// File: rtl/pixel_event_encoder.sv
// pixel_event_encoder
// Latency-coding event source. Buffers one frame of p_s pixels, then walks
// latency slots 0..SMAX and emits one one-hot event per firing pixel, with
// p_gap idle cycles after every event. Brighter pixels land in earlier slots;
// within a slot pixels fire in ascending index order.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_pixel        pixel intensity, raster order
//   i_pixel_valid  pixel present
//   o_pixel_ready  encoder accepts a pixel (LOAD only, low during reset)
//   o_event        one-hot event pulse, bit k+1 <-> pixel k (registered)
//   o_busy         high in every state except LOAD (registered)
//   o_done         one-cycle pulse when the frame has been fully scanned
// Handshake: a pixel transfers on a rising edge where i_pixel_valid and
// o_pixel_ready are both high; outside LOAD ready is low and valid is ignored.
module pixel_event_encoder
  import pixel_event_encoder_pkg::*;
#(
  parameter int p_s         = 25,
  parameter int p_width     = 8,
  parameter int p_lat_shift = 4,
  parameter int p_min       = 16,
  parameter int p_gap       = 'h3f
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [p_width-1:0] i_pixel,
  input  logic               i_pixel_valid,
  output logic               o_pixel_ready,
  output logic [p_s:1]       o_event,
  output logic               o_busy,
  output logic               o_done
);

  localparam int SW   = calc_slot_width(p_width, p_lat_shift);
  localparam int SMAX = calc_smax(SW);
  localparam int IDXW = (p_s > 1) ? $clog2(p_s) : 1;
  localparam int GW   = (p_gap > 1) ? $clog2(p_gap) : 1;

  localparam logic [SW-1:0]   SLOT_MAX = SW'(SMAX);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(p_s - 1);

  state_e             state_q, state_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [SW-1:0]      slot_q, slot_d;
  logic [p_s-1:0]     pend_q, pend_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [p_s-1:0]     event_q, event_d;
  logic               done_q;
  logic               busy_q;
  logic [p_width-1:0] pix_q [p_s];

  logic               pix_we;
  logic               take_exit;
  logic [p_s-1:0]     scan_hits;
  logic [p_s-1:0]     pick_src;
  logic [p_s-1:0]     pick_oh;

  // One comparator per pixel: latency slot of the pixel vs the current slot,
  // qualified by the minimum-intensity threshold.
  for (genvar k = 0; k < p_s; k++) begin : g_cmp
    assign scan_hits[k] = (((~pix_q[k]) >> p_lat_shift) == p_width'(slot_q)) &&
                          (pix_q[k] >= p_width'(p_min));
  end

  // In SCAN the fresh compare result is consumed; afterwards the remaining
  // pixels of the slot live in pend_q.
  assign pick_src = (state_q == ST_SCAN) ? scan_hits : pend_q;

  lsb_onehot #(.p_w(p_s)) u_lsb (
    .vec_i    (pick_src),
    .onehot_o (pick_oh)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slot_d    = slot_q;
    pend_d    = pend_q;
    gap_d     = gap_q;
    event_d   = '0;
    pix_we    = 1'b0;
    take_exit = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (i_pixel_valid) begin
          pix_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            slot_d  = '0;
            state_d = ST_SCAN;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      ST_SCAN: begin
        if (|scan_hits) begin
          event_d = pick_oh;
          pend_d  = scan_hits & ~pick_oh;
          state_d = ST_EMIT;
        end else if (slot_q == SLOT_MAX) begin
          state_d = ST_DONE;
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      ST_EMIT: begin
        if (p_gap == 0) begin
          take_exit = 1'b1;
        end else begin
          gap_d   = GW'(p_gap - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) take_exit = 1'b1;
        else             gap_d = gap_q - GW'(1);
      end
      ST_DONE: state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase

    // Shared exit from EMIT (zero gap) and GAP: next event of this slot,
    // otherwise advance to the next slot or finish the frame.
    if (take_exit) begin
      if (|pend_q) begin
        event_d = pick_oh;
        pend_d  = pend_q & ~pick_oh;
        state_d = ST_EMIT;
      end else if (slot_q == SLOT_MAX) begin
        state_d = ST_DONE;
      end else begin
        slot_d  = slot_q + SW'(1);
        state_d = ST_SCAN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      slot_q  <= '0;
      pend_q  <= '0;
      gap_q   <= '0;
      event_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      event_q <= event_d;
      done_q  <= (state_d == ST_DONE);
      busy_q  <= (state_d != ST_LOAD);
    end
  end

  // Frame storage needs no reset: every frame overwrites all entries.
  always_ff @(posedge i_clk) begin
    if (pix_we && !i_rst) pix_q[idx_q] <= i_pixel;
  end

  assign o_pixel_ready = (state_q == ST_LOAD) && !i_rst;
  assign o_event       = event_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_pixel_event_encoder.sv
module tb_pixel_event_encoder;

  localparam int P_S     = 25;
  localparam int P_W     = 8;
  localparam int P_SHIFT = 4;
  localparam int P_MIN   = 16;
  localparam int P_GAP   = 2;
  localparam int SMAX    = (1 << (P_W - P_SHIFT)) - 1;
  localparam int PIX_MAX = (1 << P_W) - 1;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic [P_W-1:0] pixel;
  logic           valid;
  logic           ready;
  logic [P_S:1]   ev;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  pixel_event_encoder #(
    .p_s(P_S), .p_width(P_W), .p_lat_shift(P_SHIFT), .p_min(P_MIN), .p_gap(P_GAP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pixel(pixel), .i_pixel_valid(valid),
    .o_pixel_ready(ready), .o_event(ev), .o_busy(busy), .o_done(done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  typedef struct {
    int             cyc;
    logic [P_S-1:0] ev;
  } exp_t;

  logic [P_W-1:0] frame [P_S];
  exp_t           exp_q [$];
  int             done_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: cycle 1 is the first cycle after the last accepted pixel.
  // Each slot costs one scan cycle plus (gap+1) cycles per firing pixel;
  // events of a slot follow its scan cycle, spaced gap+1 apart.
  task automatic build_model();
    int cur;
    int m;
    exp_t e;
    exp_q.delete();
    cur = 1;
    for (int s = 0; s <= SMAX; s++) begin
      m = 0;
      for (int k = 0; k < P_S; k++) begin
        if (int'(frame[k]) >= P_MIN && ((PIX_MAX - int'(frame[k])) / (1 << P_SHIFT)) == s) begin
          e.cyc   = cur + 1 + m * (P_GAP + 1);
          e.ev    = '0;
          e.ev[k] = 1'b1;
          exp_q.push_back(e);
          m++;
        end
      end
      cur = cur + 1 + m * (P_GAP + 1);
    end
    done_cyc = cur;
  endtask

  // ---------------- drivers ----------------
  task automatic send_frame(input bit rand_valid);
    int idx;
    int budget;
    idx = 0;
    budget = 0;
    while (idx < P_S && budget < 500) begin
      @(negedge clk);
      budget++;
      chk("ready_in_load", ready, 1);
      valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
      pixel = valid ? frame[idx] : P_W'($urandom);
      if (valid && ready) idx++;
    end
    if (idx < P_S) chk("load_timeout_transfers", idx, P_S);
  endtask

  // Checks every cycle of the frame; stop_at > 0 returns after that cycle.
  task automatic run_frame(input int stop_at);
    logic [P_S-1:0] e;
    exp_t t;
    for (int n = 1; n <= done_cyc; n++) begin
      @(negedge clk);
      e = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        t = exp_q.pop_front();
        e = t.ev;
      end
      chk($sformatf("event_cyc%0d", n), ev, e);
      chk($sformatf("done_cyc%0d", n), done, (n == done_cyc));
      chk($sformatf("busy_cyc%0d", n), busy, 1);
      chk($sformatf("ready_busy_cyc%0d", n), ready, 0);
      // Junk on the input while busy must be ignored.
      valid = 1'($urandom_range(0, 1));
      pixel = P_W'($urandom);
      if (n == stop_at) return;
    end
    @(negedge clk);
    valid = 1'b0;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("after_done_event", ev, 0);
    chk("after_done_done", done, 0);
    chk("after_done_busy", busy, 0);
    chk("after_done_ready", ready, 1);
  endtask

  task automatic fill_frame(input logic [P_W-1:0] v);
    for (int k = 0; k < P_S; k++) frame[k] = v;
  endtask

  task automatic full_frame(input bit rand_valid);
    build_model();
    send_frame(rand_valid);
    run_frame(0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    pixel = '0;
    repeat (2) @(negedge clk);
    chk("reset_ready_low", ready, 0);
    chk("reset_event", ev, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    #1;
    chk("reset_release_ready", ready, 1);

    // All bright: 25 events in slot 0, ascending index.
    fill_frame(8'hFF);
    full_frame(1'b0);

    // Single mid-intensity pixel lands in slot 7.
    fill_frame(8'h00);
    frame[7] = 8'h80;
    full_frame(1'b0);

    // Two pixels share slot 0, a third fires in slot 12.
    fill_frame(8'h00);
    frame[3]  = 8'hF0;
    frame[10] = 8'hF5;
    frame[2]  = 8'h30;
    full_frame(1'b1);

    // All below threshold: no events, 16 scan cycles.
    fill_frame(8'h0F);
    full_frame(1'b1);

    // Threshold edges: 0x10 fires (slot 14), 0x0F never, 0xFF slot 0.
    fill_frame(8'h00);
    frame[0]  = 8'h10;
    frame[1]  = 8'h0F;
    frame[24] = 8'hFF;
    full_frame(1'b1);

    // Random frames with random valid toggling during load.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < P_S; k++) frame[k] = P_W'($urandom_range(0, PIX_MAX));
      full_frame(1'b1);
    end

    // Reset during the gap after the first event of a frame.
    fill_frame(8'hFF);
    build_model();
    send_frame(1'b0);
    run_frame(3);
    rst   = 1'b1;
    valid = 1'b1;
    #1;
    chk("ready_low_in_reset", ready, 0);
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    chk("midreset_event", ev, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_ready", ready, 1);

    // Next frame must show only its own events.
    for (int k = 0; k < P_S; k++) frame[k] = P_W'($urandom_range(0, PIX_MAX));
    frame[5] = 8'hC7;
    full_frame(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
